// File: rtl/m__mips_pkg.sv
// Shared definitions for the MIPS pipeline blocks.
//   fetch_state_t : instruction-fetch FSM states
//   NOP           : all-zero instruction word (sll $0,$0,0) used as the bubble
//   PC_INCR       : sequential program-counter step
//   word_align()  : clears the byte-offset bits of an address
package m__mips_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FULL = 2'd2,
        S_DROP = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP     = 32'h0000_0000;
    localparam logic [31:0] PC_INCR = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/m__instr_fetch.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline.
// Owns the program counter, fetches words from instruction memory over a
// req/ack handshake and holds one fetched instruction for the IF/ID register.
// Redirects flush the buffer, drop any in-flight fetch and restart at the target.
//
// Ports:
//   clock__i        pipeline clock (rising edge)
//   reset_n__i      asynchronous active-low reset
//   hazard__i       1 = IF/ID consumes the presented instruction this cycle
//   redirect__i     branch/jump taken, restart at redirect_pc__i
//   redirect_pc__i  redirect target (byte offset ignored)
//   imem_req__o     fetch request
//   imem_addr__o    fetch word address
//   imem_ack__i     memory accepts the request and returns data this cycle
//   imem_data__i    fetched instruction (valid with imem_ack__i)
//   PC_4__o         PC+4 of the presented instruction, 0 when empty
//   instr__o        presented instruction, NOP when empty
//   valid__o        buffer holds a valid instruction
//   flush__o        flush to IF/ID, follows redirect__i
module m__instr_fetch
    import m__mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock__i,
    input  logic        reset_n__i,
    input  logic        hazard__i,
    input  logic        redirect__i,
    input  logic [31:0] redirect_pc__i,
    output logic        imem_req__o,
    output logic [31:0] imem_addr__o,
    input  logic        imem_ack__i,
    input  logic [31:0] imem_data__i,
    output logic [31:0] PC_4__o,
    output logic [31:0] instr__o,
    output logic        valid__o,
    output logic        flush__o
);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic [31:0]  drop_addr_q;   // address of the abandoned fetch, held until its ack
    logic [31:0]  buf_instr_q;
    logic [31:0]  buf_pc4_q;
    logic         buf_valid_q;

    logic [31:0]  pc_inc;
    logic         fetch_req;

    assign pc_inc = pc_q + PC_INCR;   // wraps modulo 2^32

    // In S_FULL a request only goes out once the presented instruction is
    // consumed; if it is not acked that cycle the FSM moves to S_REQ and the
    // same request is kept up, so req/addr stay stable until ack.
    assign fetch_req = (state_q == S_REQ) || (state_q == S_DROP) ||
                       ((state_q == S_FULL) && hazard__i);

    assign imem_req__o  = fetch_req;
    assign imem_addr__o = (state_q == S_DROP) ? drop_addr_q : pc_q;
    assign flush__o     = redirect__i;

    // Buffer contents are cleared whenever it is invalidated, so the
    // presented outputs come straight from registers.
    assign instr__o = buf_instr_q;
    assign PC_4__o  = buf_pc4_q;
    assign valid__o = buf_valid_q;

    always_ff @(posedge clock__i or negedge reset_n__i) begin
        if (!reset_n__i) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            drop_addr_q <= RESET_PC;
            buf_instr_q <= NOP;
            buf_pc4_q   <= NOP;
            buf_valid_q <= 1'b0;
        end else if (redirect__i && (state_q != S_IDLE)) begin
            pc_q        <= word_align(redirect_pc__i);
            buf_valid_q <= 1'b0;
            buf_instr_q <= NOP;
            buf_pc4_q   <= NOP;
            if (fetch_req && !imem_ack__i) begin
                // Outstanding fetch must be completed on the bus, then dropped.
                // In S_DROP imem_addr__o already is drop_addr_q, so it is kept.
                state_q     <= S_DROP;
                drop_addr_q <= imem_addr__o;
            end else begin
                state_q <= S_REQ;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (redirect__i) begin
                        pc_q <= word_align(redirect_pc__i);
                    end
                    state_q <= S_REQ;
                end
                S_REQ: begin
                    if (imem_ack__i) begin
                        buf_instr_q <= imem_data__i;
                        buf_pc4_q   <= pc_inc;
                        buf_valid_q <= 1'b1;
                        pc_q        <= pc_inc;
                        state_q     <= S_FULL;
                    end
                end
                S_FULL: begin
                    if (hazard__i) begin
                        if (imem_ack__i) begin
                            buf_instr_q <= imem_data__i;
                            buf_pc4_q   <= pc_inc;
                            pc_q        <= pc_inc;
                        end else begin
                            buf_valid_q <= 1'b0;
                            buf_instr_q <= NOP;
                            buf_pc4_q   <= NOP;
                            state_q     <= S_REQ;
                        end
                    end
                end
                S_DROP: begin
                    if (imem_ack__i) begin
                        state_q <= S_REQ;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/m__instr_fetch.md
# m__instr_fetch

Instruction-fetch (IF) stage of the 5-stage MIPS pipeline. It owns the program counter and issues word fetches to instruction memory over a req/ack handshake. It buffers one fetched instruction and presents it, together with PC+4, to the IF/ID pipeline register. Branch/jump redirects from later stages flush the buffer, discard any in-flight fetch and restart at the new target.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0)

Ports:
- clock__i  in  1  pipeline clock; all state on rising edge
- reset_n__i  in  1  asynchronous, active-low reset
- hazard__i  in  1  downstream stall, active-low: 0 = IF/ID holds (no consume), 1 = IF/ID captures this cycle
- redirect__i  in  1  branch/jump taken; load redirect_pc__i
- redirect_pc__i  in  32  redirect target; bits [1:0] ignored (forced 0)
- imem_req__o  out  1  fetch request
- imem_addr__o  out  32  fetch word address
- imem_ack__i  in  1  memory accepts request and returns imem_data__i this cycle
- imem_data__i  in  32  fetched instruction, valid only with imem_ack__i
- PC_4__o  out  32  PC+4 of presented instruction, 0 when no valid instruction
- instr__o  out  32  presented instruction, 32'h0 (NOP) when no valid instruction
- valid__o  out  1  buffer holds a valid instruction
- flush__o  out  1  flush to IF/ID, combinationally equal to redirect__i

## Operation
- State: pc_q[31:0], buf_instr, buf_pc4, buf_valid, FSM {S_IDLE, S_REQ, S_FULL, S_DROP}.
- Reset: pc_q=RESET_PC, buf_valid=0, buf_instr=0, buf_pc4=0, state S_IDLE; therefore imem_req__o=0, valid__o=0, instr__o=0, PC_4__o=0, imem_addr__o=RESET_PC.
- S_IDLE: no request; next S_REQ.
- S_REQ: imem_req__o=1, imem_addr__o=pc_q. On ack: buf<=imem_data__i, buf_pc4<=pc_q+4, buf_valid<=1, pc_q<=pc_q+4, go S_FULL.
- S_FULL: buffer presented. If hazard__i=0: no request, hold everything. If hazard__i=1: instruction consumed; imem_req__o=1 for pc_q. Ack in the same cycle refills the buffer (stay S_FULL). No ack: buf_valid<=0, go S_REQ.
- Request rule: once imem_req__o rises, it and imem_addr__o stay stable until ack, including in S_DROP.
- Redirect (highest priority, any state except S_IDLE): pc_q<=redirect_pc__i&~3, buf_valid<=0.
  - Request pending without ack: go S_DROP. Old address is held until ack, and the returned data is discarded.
  - Ack in the same cycle, or no request pending: go S_REQ.
- S_DROP: imem_req__o=1 with the old address. Ack: discard data, go S_REQ. A further redirect updates pc_q and stays in S_DROP.
- Redirect in S_IDLE: pc_q updated, next S_REQ.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC increments to 32'h0000_0000.

## Timing
- Zero-wait memory (ack same cycle as req), no stalls: one instruction per cycle after the first. First valid__o is 2 cycles after reset release (S_IDLE, S_REQ).
- N-cycle memory latency: valid__o rises the cycle after ack.
- Redirect: flush__o in the same cycle. First target instruction is valid 1 cycle after its ack.
- Reset assertion mid-operation: immediate return to reset values. The outstanding memory request is abandoned; memory shares reset_n__i.
- Outputs instr__o/PC_4__o/valid__o are driven from registers only. imem_req__o is from state plus hazard__i. flush__o is from redirect__i.

## Structure
- Shared package m__mips_pkg: fetch FSM enum type, NOP constant 32'h0000_0000, PC_INCR constant 32'd4.
- Single module; no sub-module. The PC incrementer and buffer are inline.

## Test plan
- Reset, RESET_PC=32'h0000_0100, zero-wait memory returning addr as data: valid__o high from cycle 2 with instr__o=32'h100, PC_4__o=32'h104, then 32'h104/32'h108 every cycle.
- 3-cycle ack latency: req held with stable addr 3 cycles. Instruction valid the cycle after ack, and the next req starts only on consume.
- hazard__i=0 for 4 cycles while S_FULL: imem_req__o=0, outputs frozen. Release: next fetch issues the same cycle.
- Redirect to 32'h0000_2003 while a req to 32'h10 is pending without ack: flush__o=1, valid__o=0. The ack for 32'h10 is discarded, and the next req is to 32'h2000.
- Redirect coinciding with ack: data dropped, next req to target. A second redirect during S_DROP: last target wins.
- pc_q=32'hFFFF_FFFC fetch: PC_4__o=0, next req addr 32'h0. Async reset mid-wait: all outputs at reset values immediately, same cycle.
